// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps a loadable N-input truth table and streams
// the selected rows (all / minterms / maxterms) over valid/ready.
module truth_table_scanner #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [(1<<N)-1:0] table_in_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  output logic             busy_o,
  output logic             row_valid_o,
  input  logic             row_ready_i,
  output logic [N-1:0]     row_idx_o,
  output logic             row_val_o,
  output logic             done_o,
  output logic [N:0]       ones_cnt_o
);

  localparam int W  = 1 << N;
  localparam int W1 = N + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   tbl_q, tbl_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [N:0]     ones_q, ones_d;
  logic [1:0]     mode_q, mode_d;

  logic cur;
  logic qual;
  logic valid;
  logic adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tbl_q   <= '0;
      idx_q   <= '0;
      ones_q  <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    mode_d  = mode_q;
    cur     = tbl_q[idx_q];
    qual    = 1'b1;

    unique case (mode_q)
      2'b01:   qual = cur;
      2'b10:   qual = ~cur;
      default: qual = 1'b1;
    endcase

    valid = (state_q == S_SCAN) && qual;
    // Non-qualifying rows are skipped in one cycle, never stalled.
    adv   = (state_q == S_SCAN) && (!qual || row_ready_i);

    unique case (state_q)
      S_IDLE: begin
        if (load_i) tbl_d = table_in_i;
        if (start_i) begin
          mode_d  = mode_i;
          idx_d   = '0;
          ones_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (adv) begin
          ones_d = ones_q + W1'(cur);
          if (&idx_q) state_d = S_DONE;
          else        idx_d   = idx_q + N'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign row_valid_o = valid;
  assign row_idx_o   = valid ? idx_q : '0;
  assign row_val_o   = valid & cur;
  assign done_o      = (state_q == S_DONE);
  assign ones_cnt_o  = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed sweeps on N=3 and N=4 scanners with
// hand-computed row masks, done timing and ones counts.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       load3, start3, ready3;
  logic [7:0] tin3;
  logic [1:0] mode3;
  logic       busy3, valid3, val3, done3;
  logic [2:0] idx3;
  logic [3:0] ones3;

  logic        load4, start4, ready4;
  logic [15:0] tin4;
  logic [1:0]  mode4;
  logic        busy4, valid4, val4, done4;
  logic [3:0]  idx4;
  logic [4:0]  ones4;

  int checks = 0;
  int errors = 0;

  truth_table_scanner #(.N(3)) u3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load3),
    .table_in_i (tin3),
    .start_i    (start3),
    .mode_i     (mode3),
    .busy_o     (busy3),
    .row_valid_o(valid3),
    .row_ready_i(ready3),
    .row_idx_o  (idx3),
    .row_val_o  (val3),
    .done_o     (done3),
    .ones_cnt_o (ones3)
  );

  truth_table_scanner #(.N(4)) u4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load4),
    .table_in_i (tin4),
    .start_i    (start4),
    .mode_i     (mode4),
    .busy_o     (busy4),
    .row_valid_o(valid4),
    .row_ready_i(ready4),
    .row_idx_o  (idx4),
    .row_val_o  (val4),
    .done_o     (done4),
    .ones_cnt_o (ones4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point in IDLE; returns at a sample point in IDLE.
  task automatic sweep3(input string tag, input logic [7:0] tbl,
                        input bit ld, input logic [1:0] md,
                        input int stall_n, input bit poke,
                        input logic [7:0] emask, input logic [7:0] evals,
                        input int edone, input int eones);
    logic [7:0] mask, vals;
    logic [2:0] pidx;
    logic       pval;
    int  dcyc, stalls;
    bit  pv, pr, busy_ok;
    mask = '0; vals = '0; dcyc = -1; stalls = 0;
    pv = 0; pr = 1; busy_ok = 1; pidx = '0; pval = 0;
    load3 = ld; tin3 = tbl; start3 = 1; mode3 = md; ready3 = 1;
    tick();
    load3 = 0; start3 = 0; mode3 = ~md; tin3 = ~tbl;
    for (int c = 1; c <= 40; c++) begin
      if (pv && !pr)
        check({tag, "/hold"}, {27'd0, valid3, idx3, val3},
              {27'd0, 1'b1, pidx, pval});
      if (!busy3) busy_ok = 0;
      if (valid3) begin
        mask[idx3] = 1'b1;
        vals[idx3] = val3;
      end
      pv = valid3; pidx = idx3; pval = val3;
      ready3 = 1;
      if (valid3 && idx3 == 3'd4 && stalls < stall_n) begin
        ready3 = 0;
        stalls++;
      end
      pr = ready3;
      if (poke && c == 3) begin
        start3 = 1; load3 = 1; mode3 = 2'b11;
      end else begin
        start3 = 0; load3 = 0;
      end
      if (done3) begin
        dcyc = c;
        break;
      end
      tick();
    end
    start3 = 0; load3 = 0; ready3 = 1;
    check({tag, "/done_cyc"}, dcyc, edone);
    check({tag, "/ones"}, {28'd0, ones3}, eones);
    check({tag, "/mask"}, {24'd0, mask}, {24'd0, emask});
    check({tag, "/vals"}, {24'd0, vals}, {24'd0, evals});
    check({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
    tick();
    check({tag, "/idle"}, {30'd0, busy3, done3}, 32'd0);
    check({tag, "/ones_hold"}, {28'd0, ones3}, eones);
  endtask

  initial begin
    int dcyc;
    bit saw_done;
    logic [15:0] mask4;
    rst_n = 0;
    load3 = 0; start3 = 0; ready3 = 1; tin3 = '0; mode3 = '0;
    load4 = 0; start4 = 0; ready4 = 1; tin4 = '0; mode4 = '0;
    repeat (3) tick();
    check("rst3", {19'd0, busy3, valid3, idx3, val3, done3, ones3}, 32'd0);
    check("rst4", {17'd0, busy4, valid4, idx4, val4, done4, ones4}, 32'd0);
    rst_n = 1;
    tick();

    sweep3("m00", 8'hFC, 1, 2'b00, 0, 0, 8'hFF, 8'hFC, 9, 6);
    sweep3("m01", 8'hFC, 1, 2'b01, 0, 0, 8'hFC, 8'hFC, 9, 6);
    sweep3("m10", 8'hFC, 1, 2'b10, 0, 0, 8'h03, 8'h00, 9, 6);
    sweep3("m11", 8'hFC, 1, 2'b11, 0, 0, 8'hFF, 8'hFC, 9, 6);
    sweep3("bp", 8'hFC, 1, 2'b00, 3, 0, 8'hFF, 8'hFC, 12, 6);
    sweep3("empty1", 8'h00, 1, 2'b01, 0, 0, 8'h00, 8'h00, 9, 0);
    sweep3("empty0", 8'hFF, 1, 2'b10, 0, 0, 8'h00, 8'h00, 9, 8);
    sweep3("poke", 8'hFC, 1, 2'b00, 0, 1, 8'hFF, 8'hFC, 9, 6);
    sweep3("noload", 8'h00, 0, 2'b00, 0, 0, 8'hFF, 8'hFC, 9, 6);

    // Abort a sweep with reset at t+4.
    load3 = 1; tin3 = 8'hFC; start3 = 1; mode3 = 2'b00;
    tick();
    load3 = 0; start3 = 0;
    saw_done = 0;
    for (int c = 1; c < 4; c++) begin
      if (done3) saw_done = 1;
      tick();
    end
    rst_n = 0;
    tick();
    check("abort_outs", {19'd0, busy3, valid3, idx3, val3, done3, ones3},
          32'd0);
    rst_n = 1;
    for (int c = 0; c < 12; c++) begin
      if (done3 || busy3) saw_done = 1;
      tick();
    end
    check("abort_nodone", {31'd0, saw_done}, 32'd0);
    sweep3("post_rst", 8'hFC, 0, 2'b00, 0, 0, 8'hFF, 8'h00, 9, 0);

    // N=4 minterm sweep.
    load4 = 1; tin4 = 16'h8001; start4 = 1; mode4 = 2'b01;
    tick();
    load4 = 0; start4 = 0; mode4 = 2'b00;
    mask4 = '0; dcyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (valid4) mask4[idx4] = 1'b1;
      if (done4) begin
        dcyc = c;
        break;
      end
      tick();
    end
    check("n4/done_cyc", dcyc, 32'd17);
    check("n4/mask", {16'd0, mask4}, 32'h8001);
    check("n4/ones", {27'd0, ones4}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

- Parametrised sequential truth-table evaluator.
- Holds a loadable N-input Boolean function as a 2^N-bit truth table.
- On `start`, sweeps every input combination and streams the rows under a valid/ready handshake. Depending on mode it emits all rows, minterms only or maxterms only, and it counts the 1-rows.
- Intended as the reusable engine behind the guide exercises that print full truth tables for an expression of x, y, z.

## Interface
- `N`, default 3: number of function inputs; table width is 2^N, 1 <= N <= 8.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `load` in 1: when high in IDLE, `table_in` is written to the internal table register.
- `table_in` in 2^N: truth table, bit i = function value for input combination i. Bit N-1 of i is the first variable (x), bit 0 the last.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `mode` in 2: 00 all rows, 01 minterms only (value 1), 10 maxterms only (value 0), 11 treated as 00. Sampled at `start`.
- `busy` out 1: high whenever state is not IDLE.
- `row_valid` out 1: a row is offered.
- `row_ready` in 1: consumer accepts the offered row.
- `row_idx` out N: input combination of the offered row.
- `row_val` out 1: function value of the offered row.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `ones_cnt` out N+1: number of table rows equal to 1 seen in the current/last sweep.

## Operation
- States:
  - IDLE: `load` writes the table. `start` latches mode, clears `idx` and `ones_cnt`, then goes to SCAN.
  - SCAN: walks `idx` from 0 to 2^N-1.
  - DONE: lasts one cycle, asserts `done`, then returns to IDLE.
- In SCAN, row `idx` qualifies if mode is 00/11, or if `table[idx]` matches the mode (1 for 01, 0 for 10).
- `row_valid` = SCAN and qualifies. `row_idx` = `idx` and `row_val` = `table[idx]` while valid; both are driven 0 otherwise.
- `idx` advances when either:
  - `row_valid && row_ready` (transfer), or
  - the row does not qualify (skip, exactly one cycle).
- `ones_cnt` increments by `table[idx]` on every advance. All 2^N rows are counted regardless of mode. The final value holds until the next accepted `start`.
- Advancing from `idx` = 2^N-1 moves to DONE. `idx` does not wrap within a sweep.
- Ignored while `busy`: `load`, `start`, and `mode` changes. The table is stable for the whole sweep.
- `load` and `start` in the same IDLE cycle: the table is written, and the sweep uses the newly loaded table.

## Timing
- Reset values (every output): `busy` 0, `row_valid` 0, `row_idx` 0, `row_val` 0, `done` 0, `ones_cnt` 0. Reset also clears the table and returns the FSM to IDLE.
- Reset asserted mid-sweep aborts the sweep on that edge, with no `done` pulse.
- Sweep timing for `start` accepted at edge t:
  - SCAN occupies cycles t+1 .. t+2^N+S, where S is the number of stall cycles (valid high, ready low).
  - `done` is high in cycle t+2^N+S+1.
  - IDLE resumes the cycle after that; a new `start` is accepted there.
- Handshake:
  - While `row_valid` is high and `row_ready` is low, `row_idx`/`row_val` are held stable.
  - Valid never drops without a transfer, except on reset.
- `row_ready` is a don't-care when `row_valid` is low. Skipped rows never stall.
- `busy` is high from t+1 through the DONE cycle inclusive.

## Test plan
- N=3, load 8'hFC (x|y), mode 00, ready=1: rows idx 0..7 with values 0,0,1,1,1,1,1,1 in cycles t+1..t+8; `done` at t+9; `ones_cnt` = 6.
- Same table, mode 01 and mode 10:
  - Mode 01: valid only for idx 2..7.
  - Mode 10: valid only for idx 0,1.
  - Both: `done` at t+9, `ones_cnt` = 6.
- Backpressure, mode 00: `row_ready` low for 3 cycles while idx=4 is offered. `row_idx`=4 and `row_val`=1 held; `done` moves to t+12.
- Empty selection: table 8'h00, mode 01. `row_valid` never high; `done` at t+9; `ones_cnt` = 0. Repeat with 8'hFF, mode 10: same timing, `ones_cnt` = 8.
- Protocol and reset:
  - `start`/`load` pulsed mid-sweep are ignored: same rows, same table.
  - `rst_n` low at t+4: all outputs 0 the next cycle, no `done` pulse, table reads 0 on the next sweep.
- N=4: load 16'h8001, mode 01. Rows idx 0 and 15 emitted; `done` at t+17; `ones_cnt` = 2.
